// File: rtl/rc5_decrypt_core.sv
// rc5_decrypt_core: iterative RC5-32/12/16 block decryptor.
// One half-round per clock; the core drives the S[] read index itself and
// expects the key table to answer combinationally in the same cycle.
module rc5_decrypt_core #(
  parameter int W   = 32,
  parameter int R   = 12,
  parameter int T   = 26,
  parameter int LGW = 5,
  parameter int AW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  ct_a,
  input  logic [W-1:0]  ct_b,
  output logic [AW-1:0] s_addr,
  input  logic [W-1:0]  s_data,
  output logic          busy,
  output logic          out_valid,
  output logic [W-1:0]  pt_a,
  output logic [W-1:0]  pt_b
);

  // Each round consumes two table entries, so the round counter needs one
  // bit less than the table address.
  localparam int IW = $clog2(T) - 1;

  typedef enum logic [2:0] {
    IDLE,
    RND_B,
    RND_A,
    FIN_B,
    FIN_A
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [IW-1:0] i_q;
  logic          accept;
  logic [W-1:0]  a_round;
  logic [W-1:0]  b_round;

  // Right rotate; the left-shift amount is (-amt) mod W so a zero rotate
  // degenerates cleanly to the identity.
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] amt);
    logic [LGW-1:0] back;
    back = LGW'(0) - amt;
    return (x >> amt) | (x << back);
  endfunction

  assign in_ready = (state_q == IDLE) && key_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // Half-round results use the other word's value from before this update.
  assign b_round = rotr(b_q - s_data, a_q[LGW-1:0]) ^ a_q;
  assign a_round = rotr(a_q - s_data, b_q[LGW-1:0]) ^ b_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and key-table addressing for the current half-round.
  always_comb begin
    state_d = state_q;
    s_addr  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RND_B;
        end
      end
      RND_B: begin
        s_addr  = AW'({i_q, 1'b1});
        state_d = RND_A;
      end
      RND_A: begin
        s_addr  = AW'({i_q, 1'b0});
        state_d = (i_q > IW'(1)) ? RND_B : FIN_B;
      end
      FIN_B: begin
        s_addr  = AW'(1);
        state_d = FIN_A;
      end
      FIN_A: begin
        s_addr  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: load on acceptance, update one word per half-round, and
  // publish the plaintext with a single-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      i_q       <= '0;
      pt_a      <= '0;
      pt_b      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q <= ct_a;
            b_q <= ct_b;
            i_q <= IW'(R);
          end
        end
        RND_B: begin
          b_q <= b_round;
        end
        RND_A: begin
          a_q <= a_round;
          if (i_q > IW'(1)) begin
            i_q <= i_q - IW'(1);
          end
        end
        FIN_B: begin
          b_q <= b_q - s_data;
        end
        FIN_A: begin
          pt_a      <= a_q - s_data;
          pt_b      <= b_q;
          out_valid <= 1'b1;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
